// File: rtl/lsu_mem_port.sv
// Load/store port between the CPU controller and a req/ack memory bus.
// One transaction at a time, with a bus timeout so a dead memory cannot stall the CPU.
module lsu_mem_port #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        en_ls,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] d_out,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t             state_q, state_d;
    mem_cmd_t           cmd_q, cmd_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               req_valid;

    // 2'b11 is reserved and behaves like idle
    assign req_valid = (en_ls == 2'b01) || (en_ls == 2'b10);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dout_d  = dout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d.we    = en_ls[1];
                    cmd_d.addr  = addr;
                    cmd_d.wdata = wdata;
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Ack takes priority over a timeout firing on the same edge
                if (mem_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                    if (!cmd_q.we) begin
                        dout_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // A request still held from the last transaction must not re-trigger
                if (en_ls == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ls_done   = done_q;
    assign ls_err    = err_q;
    assign d_out     = dout_q;
    assign mem_req   = req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: instance a uses TIMEOUT=8, instance b TIMEOUT=4.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;

    logic [1:0]  en_ls_a = '0;
    logic [15:0] rdata_a = '0;
    logic        ack_a = 1'b0;
    logic        done_a, err_a, req_a, we_a;
    logic [15:0] dout_a, wd_a;
    logic [7:0]  ad_a;

    logic [1:0]  en_ls_b = '0;
    logic [15:0] rdata_b = '0;
    logic        ack_b = 1'b0;
    logic        done_b, err_b, req_b, we_b;
    logic [15:0] dout_b, wd_b;
    logic [7:0]  ad_b;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(8)) u_a (
        .clk(clk), .reset(reset), .en_ls(en_ls_a), .addr(addr), .wdata(wdata),
        .ls_done(done_a), .d_out(dout_a), .ls_err(err_a), .mem_req(req_a),
        .mem_we(we_a), .mem_addr(ad_a), .mem_wdata(wd_a),
        .mem_rdata(rdata_a), .mem_ack(ack_a)
    );

    lsu_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(4)) u_b (
        .clk(clk), .reset(reset), .en_ls(en_ls_b), .addr(addr), .wdata(wdata),
        .ls_done(done_b), .d_out(dout_b), .ls_err(err_b), .mem_req(req_b),
        .mem_we(we_b), .mem_addr(ad_b), .mem_wdata(wd_b),
        .mem_rdata(rdata_b), .mem_ack(ack_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, ndone, lasterr;

        // reset state
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_req", req_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_addr", ad_a, 0);
        chk("rst_wdata", wd_a, 0);
        chk("rst_dout", dout_a, 0);
        reset = 1'b1;
        tick();

        // load, 1-cycle ack
        en_ls_a = 2'b01; addr = 8'h3C; wdata = 16'h5A5A;
        tick();
        chk("ld1_req", req_a, 1);
        chk("ld1_we", we_a, 0);
        chk("ld1_addr", ad_a, 8'h3C);
        chk("ld1_done_early", done_a, 0);
        ack_a = 1'b1; rdata_a = 16'hBEEF; en_ls_a = 2'b00;
        tick();
        chk("ld1_done", done_a, 1);
        chk("ld1_err", err_a, 0);
        chk("ld1_dout", dout_a, 16'hBEEF);
        chk("ld1_req_drop", req_a, 0);
        ack_a = 1'b0; rdata_a = 16'h0000;
        tick();
        chk("ld1_done_1cyc", done_a, 0);
        chk("ld1_dout_hold", dout_a, 16'hBEEF);

        // store, ack on the 5th bus cycle; inputs scrambled while busy
        en_ls_a = 2'b10; addr = 8'h10; wdata = 16'h1234;
        tick();
        en_ls_a = 2'b00; addr = 8'hFF; wdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("st_req%0d", i), req_a, 1);
            chk($sformatf("st_we%0d", i), we_a, 1);
            chk($sformatf("st_wd%0d", i), wd_a, 16'h1234);
            chk($sformatf("st_ad%0d", i), ad_a, 8'h10);
            chk($sformatf("st_nodone%0d", i), done_a, 0);
            if (i == 4) begin
                ack_a = 1'b1; rdata_a = 16'hDEAD;
            end
            tick();
        end
        chk("st_done", done_a, 1);
        chk("st_err", err_a, 0);
        chk("st_dout", dout_a, 16'hBEEF);
        chk("st_req_drop", req_a, 0);
        ack_a = 1'b0;
        tick();
        chk("st_done_1cyc", done_a, 0);

        // timeout: load, no ack, TIMEOUT=8
        en_ls_a = 2'b01; addr = 8'h55;
        tick();
        en_ls_a = 2'b00;
        nreq = 0; ndone = 0; lasterr = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_a) nreq++;
            if (done_a) begin
                ndone++;
                lasterr = err_a;
            end
            tick();
        end
        chk("to_req_cycles", nreq, 8);
        chk("to_done_cnt", ndone, 1);
        chk("to_err", lasterr, 1);
        chk("to_dout", dout_a, 16'hBEEF);

        // held request: ack held high throughout, en_ls held 01
        ack_a = 1'b1; rdata_a = 16'h1111; en_ls_a = 2'b01; addr = 8'h22;
        tick();
        chk("hd_req", req_a, 1);
        tick();
        chk("hd_done", done_a, 1);
        chk("hd_dout", dout_a, 16'h1111);
        nreq = 0; ndone = 0;
        for (int k = 0; k < 11; k++) begin
            tick();
            if (req_a) nreq++;
            if (done_a) ndone++;
        end
        chk("hd_no_req", nreq, 0);
        chk("hd_no_done", ndone, 0);
        en_ls_a = 2'b00;
        tick();
        chk("hd_idle_req", req_a, 0);
        en_ls_a = 2'b01; rdata_a = 16'h2222;
        tick();
        chk("hd2_req", req_a, 1);
        tick();
        chk("hd2_done", done_a, 1);
        chk("hd2_dout", dout_a, 16'h2222);
        ack_a = 1'b0; en_ls_a = 2'b00;
        tick();

        // async reset mid-busy
        en_ls_a = 2'b10; addr = 8'h40; wdata = 16'hAAAA;
        tick();
        en_ls_a = 2'b00;
        tick();
        chk("ar_req_busy", req_a, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req_drop", req_a, 0);
        chk("ar_done", done_a, 0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_a) ndone++;
        end
        chk("ar_no_done", ndone, 0);
        reset = 1'b1;
        tick();
        chk("ar_idle_done", done_a, 0);
        en_ls_a = 2'b01; addr = 8'h3C;
        tick();
        chk("ar_ld_req", req_a, 1);
        ack_a = 1'b1; rdata_a = 16'hC0DE; en_ls_a = 2'b00;
        tick();
        chk("ar_ld_done", done_a, 1);
        chk("ar_ld_dout", dout_a, 16'hC0DE);
        ack_a = 1'b0;
        tick();

        // ack/timeout collision on instance b (TIMEOUT=4)
        en_ls_b = 2'b01; addr = 8'h77;
        tick();
        en_ls_b = 2'b00;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("co_req%0d", k), req_b, 1);
            chk($sformatf("co_nodone%0d", k), done_b, 0);
            tick();
        end
        chk("co_req3", req_b, 1);
        ack_b = 1'b1; rdata_b = 16'h4444;
        tick();
        chk("co_done", done_b, 1);
        chk("co_err", err_b, 0);
        chk("co_dout", dout_b, 16'h4444);
        ack_b = 1'b0;
        tick();

        // reserved code
        en_ls_a = 2'b11; addr = 8'h99;
        nreq = 0; ndone = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (req_a) nreq++;
            if (done_a) ndone++;
        end
        chk("rs_no_req", nreq, 0);
        chk("rs_no_done", ndone, 0);
        chk("rs_dout", dout_a, 16'hC0DE);
        en_ls_a = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit (LSU) that services the CPU controller's load/store request.
- Takes en_ls (01 = load, 10 = store) with an address and store data, and runs a req/ack transaction on a simple external memory bus.
- Returns read data for the CPU's register C input mux, and pulses ls_done so the controller leaves its execute state.
- Includes a bus timeout so a dead memory cannot hang the CPU.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, data width; matches the CPU register width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (valid range 1..65535).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- en_ls  input  2  request from CPU: 00 idle, 01 load, 10 store, 11 reserved (treated as idle)
- addr  input  ADDR_W  memory address, sampled when a request is accepted
- wdata  input  DATA_W  store data, sampled when a request is accepted
- ls_done  output  1  one-cycle completion pulse to the CPU
- d_out  output  DATA_W  load result, held until the next completed load
- ls_err  output  1  set together with ls_done when the transaction timed out
- mem_req  output  1  bus request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1
- mem_addr  output  ADDR_W  bus address, valid while mem_req = 1
- mem_wdata  output  DATA_W  bus write data
- mem_rdata  input  DATA_W  bus read data, valid when mem_ack = 1
- mem_ack  input  1  bus acknowledge, one or more cycles

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - ls_done, ls_err, mem_req, mem_we = 0; mem_addr, mem_wdata, d_out = 0; timeout counter = 0.
  - Reset asserted mid-transaction drops mem_req immediately. No ls_done is issued for the aborted access.
- All outputs are registered.
- IDLE:
  - en_ls = 01 or 10 accepts a request. On that edge: latch addr and wdata, set mem_we = en_ls[1], assert mem_req, clear the counter, go to BUSY.
  - en_ls = 00 or 11: stay in IDLE.
- BUSY:
  - mem_req stays high; mem_addr, mem_we and mem_wdata stay stable. Changes on en_ls, addr or wdata are ignored.
  - mem_ack = 1:
    - Drop mem_req on the next edge.
    - For a load, capture mem_rdata into d_out on that edge.
    - Pulse ls_done = 1 with ls_err = 0. Go to HOLD.
  - No ack:
    - Counter increments each cycle.
    - When the counter reaches TIMEOUT - 1 with no ack, drop mem_req and pulse ls_done = 1 with ls_err = 1. Go to HOLD.
    - d_out is unchanged on a timed-out load.
  - If mem_ack arrives in the same cycle the timeout would fire, the ack wins: success, ls_err = 0.
- HOLD:
  - ls_done, ls_err = 0.
  - Wait until en_ls = 00, then go to IDLE. This prevents a request that is still held from re-triggering.
  - If en_ls is still nonzero, stay in HOLD indefinitely.
- Latency:
  - Request accepted at edge N, so mem_req = 1 after edge N.
  - Ack sampled high at edge N+k (k ≥ 1) gives ls_done = 1 during the cycle after edge N+k, and d_out valid in that same cycle.
  - Minimum total: en_ls high to ls_done high = 2 edges.
- ls_done is exactly one cycle wide per accepted request. There is never more than one outstanding transaction.
- The CPU reads d_out in the cycle ls_done is high. d_out must remain valid there and afterwards until the next successful load.
- Stores never modify d_out.
- Extra mem_ack cycles are ignored: an ack held past the completion edge, or an ack outside BUSY.

Test Plan:
- Load, 1-cycle ack:
  - Stimulus: en_ls = 01, addr = 8'h3C; memory acks on the first mem_req cycle with rdata = 16'hBEEF.
  - Required: mem_we = 0, mem_addr = 3C; ls_done exactly one cycle, 2 edges after the request; d_out = BEEF; ls_err = 0.
- Store, 5-cycle ack delay:
  - Stimulus: en_ls = 10, addr = 8'h10, wdata = 16'h1234; wdata changed to 0000 during BUSY.
  - Required: mem_we = 1 and mem_wdata = 1234 held for all 5 cycles; one ls_done; d_out unchanged.
- Timeout:
  - Stimulus: TIMEOUT = 8, load with no ack ever.
  - Required: mem_req high for exactly 8 cycles then low; ls_done = 1 with ls_err = 1; d_out keeps its previous value.
- Held request:
  - Stimulus: en_ls = 01 held 10 cycles beyond ls_done, then 00, then 01 again.
  - Required: exactly one transaction during the hold; a second transaction starts only after the 00 cycle.
- Async reset mid-BUSY:
  - Stimulus: assert reset between clock edges while mem_req = 1.
  - Required: mem_req = 0 immediately, no ls_done; after release, a load completes normally.
- Ack/timeout collision and reserved code:
  - Stimulus: TIMEOUT = 4 with ack arriving on the 4th BUSY cycle; separately, en_ls = 11.
  - Required: collision gives ls_err = 0 and d_out = rdata; en_ls = 11 gives no mem_req.
